codec_cfg_sequencer: RTL

Upstream feeder for the I2C controller. Walks a fixed WM8731 register table after reset or on request. For each entry it presents one 24-bit I2C word, pulses start, waits for done, and checks ack. A NACKed entry is retried; the sequence aborts with an error flag once retries are exhausted. The outputs cfg_done and cfg_error gate the audio datapath enable.

---
 rtl/codec_cfg_pkg.sv | 48 ++++
 rtl/codec_cfg_rom.sv | 24 ++
 rtl/codec_cfg_sequencer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/codec_cfg_pkg.sv
// Shared definitions for the WM8731 configuration sequencer.
// Holds the FSM state encoding, the codec register addresses and the
// power-up register table sent over I2C.
package codec_cfg_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PWRUP,
        ST_LOAD,
        ST_ISSUE,
        ST_WAIT,
        ST_RETRY,
        ST_GAP,
        ST_FINISH,
        ST_FAIL
    } state_t;

    // WM8731 register addresses (7-bit)
    localparam logic [6:0] R0  = 7'h00;  // left line in
    localparam logic [6:0] R1  = 7'h01;  // right line in
    localparam logic [6:0] R2  = 7'h02;  // left headphone out
    localparam logic [6:0] R3  = 7'h03;  // right headphone out
    localparam logic [6:0] R4  = 7'h04;  // analogue path
    localparam logic [6:0] R5  = 7'h05;  // digital path
    localparam logic [6:0] R6  = 7'h06;  // power down
    localparam logic [6:0] R7  = 7'h07;  // digital interface format
    localparam logic [6:0] R8  = 7'h08;  // sampling control
    localparam logic [6:0] R9  = 7'h09;  // active control
    localparam logic [6:0] R15 = 7'h0F;  // reset

    localparam int TABLE_LEN = 11;

    // Table entries are {reg_addr[6:0], reg_val[8:0]}; element 0 is sent first.
    localparam logic [0:TABLE_LEN-1][15:0] CFG_TABLE = {
        {R15, 9'h000},  // soft reset
        {R0,  9'h017},
        {R1,  9'h017},
        {R2,  9'h079},
        {R3,  9'h079},
        {R4,  9'h012},
        {R5,  9'h000},
        {R6,  9'h000},
        {R7,  9'h042},
        {R8,  9'h000},
        {R9,  9'h001}   // activate interface last
    };

endpackage

// File: rtl/codec_cfg_rom.sv
// Combinational lookup from table index to the full 24-bit I2C word
// {DEV_ADDR, reg_addr, reg_val}. Indices past the table return an
// all-zero register field.
module codec_cfg_rom
    import codec_cfg_pkg::*;
#(
    parameter logic [7:0] DEV_ADDR = 8'h34
) (
    input  logic [3:0]  index,
    output logic [23:0] word
);

    logic [15:0] entry;

    // Table lookup with out-of-range guard
    always_comb begin
        entry = 16'h0000;
        if (int'(index) < TABLE_LEN) begin
            entry = CFG_TABLE[index];
        end
        word = {DEV_ADDR, entry};
    end

endmodule

// File: rtl/codec_cfg_sequencer.sv
// WM8731 configuration sequencer: walks the register table after reset
// or init_req, issuing one I2C word per entry with NACK retries.
// Optional macro CODEC_CFG_TIMEOUT_EN adds a done watchdog in WAIT that
// treats a missing i2c_done as a NACK.
module codec_cfg_sequencer
    import codec_cfg_pkg::*;
#(
    parameter int          NUM_REGS       = 11,
    parameter logic [7:0]  DEV_ADDR       = 8'h34,
    parameter int          MAX_RETRY      = 3,
    parameter logic [15:0] PWRUP_CYCLES   = 16'd50000,
    parameter logic [7:0]  GAP_CYCLES     = 8'd200,
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init_req,
    output logic        i2c_start,
    output logic [23:0] i2c_data,
    input  logic        i2c_done,
    input  logic        i2c_ack,
    output logic        cfg_busy,
    output logic        cfg_done,
    output logic        cfg_error,
    output logic [3:0]  err_index
);

    localparam logic [1:0] MAX_R    = 2'(MAX_RETRY);
    localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);

    state_t      state;
    logic [15:0] cnt;      // shared PWRUP / GAP delay counter
    logic [3:0]  index;
    logic [1:0]  retry;
    logic        acked;    // last WAIT ended with ACK (vs. NACK/retry)
    logic [23:0] rom_word;
`ifdef CODEC_CFG_TIMEOUT_EN
    logic [19:0] wd_cnt;
`endif

    codec_cfg_rom #(
        .DEV_ADDR (DEV_ADDR)
    ) u_rom (
        .index (index),
        .word  (rom_word)
    );

    // Sequencer FSM with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_PWRUP;
            cnt       <= '0;
            index     <= '0;
            retry     <= '0;
            acked     <= 1'b0;
            i2c_start <= 1'b0;
            i2c_data  <= '0;
            cfg_busy  <= 1'b0;
            cfg_done  <= 1'b0;
            cfg_error <= 1'b0;
            err_index <= '0;
`ifdef CODEC_CFG_TIMEOUT_EN
            wd_cnt    <= '0;
`endif
        end else begin
            i2c_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (init_req) begin
                        cnt      <= '0;
                        cfg_busy <= 1'b1;
                        state    <= ST_PWRUP;
                    end
                end
                ST_PWRUP: begin
                    cfg_busy <= 1'b1;
                    if (cnt == PWRUP_CYCLES) begin
                        cnt   <= '0;
                        index <= '0;
                        retry <= '0;
                        state <= ST_LOAD;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_LOAD: begin
                    i2c_data  <= rom_word;
                    i2c_start <= 1'b1;
                    state     <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    // a done pulse coincident with start is not ours
`ifdef CODEC_CFG_TIMEOUT_EN
                    wd_cnt <= '0;
`endif
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i2c_done) begin
                        acked <= i2c_ack;
                        cnt   <= '0;
                        state <= i2c_ack ? ST_GAP : ST_RETRY;
                    end
`ifdef CODEC_CFG_TIMEOUT_EN
                    else if (wd_cnt == TIMEOUT_CYCLES - 20'd1) begin
                        acked <= 1'b0;
                        cnt   <= '0;
                        state <= ST_RETRY;
                    end else begin
                        wd_cnt <= wd_cnt + 20'd1;
                    end
`endif
                end
                ST_RETRY: begin
                    if (retry < MAX_R) begin
                        retry <= retry + 2'd1;
                        cnt   <= '0;
                        state <= ST_GAP;
                    end else begin
                        cfg_error <= 1'b1;
                        err_index <= index;
                        cfg_busy  <= 1'b0;
                        state     <= ST_FAIL;
                    end
                end
                ST_GAP: begin
                    if (cnt + 16'd1 >= {8'd0, GAP_CYCLES}) begin
                        cnt <= '0;
                        if (!acked) begin
                            state <= ST_LOAD;
                        end else if (index == LAST_IDX) begin
                            cfg_done <= 1'b1;
                            cfg_busy <= 1'b0;
                            state    <= ST_FINISH;
                        end else begin
                            index <= index + 4'd1;
                            retry <= '0;
                            state <= ST_LOAD;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_FINISH, ST_FAIL: begin
                    if (init_req) begin
                        cfg_done  <= 1'b0;
                        cfg_error <= 1'b0;
                        err_index <= '0;
                        cfg_busy  <= 1'b1;
                        cnt       <= '0;
                        state     <= ST_PWRUP;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
